uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmitter stage directly downstream of the TX FIFO. Pops words via the FIFO's
//  valid/read-enable interface and serialises them LSB-first onto tx_o.
//  Frame format: 1 start bit (0), p_data_bits data bits, p_stop_bits stop bits (1), no parity.
//  Consecutive frames are sent back-to-back with no idle gap.
// PARAMETERS
//  p_clk_freq_hz  50_000_000  system clock frequency in Hz
//  p_baud         115_200     line rate in bit/s; CPB = p_clk_freq_hz / p_baud (integer division)
//  p_data_bits    7           data bits per frame (5..8)
//  p_stop_bits    1           stop bits per frame (1 or 2)
// PORTS
//  clk_i          in   1            system clock, all logic on rising edge
//  rst_n_i        in   1            reset, asynchronous, active-low
//  fifo_data_i    in   p_data_bits  head word from the FIFO (combinational FIFO output)
//  fifo_valid_i   in   1            FIFO not empty
//  fifo_read_o    out  1            pop strobe to the FIFO read-enable, one cycle per word
//  tx_o           out  1            serial line, idle high, registered
//  busy_o         out  1            frame in progress (state != IDLE), registered
// BEHAVIOUR
//  Reset (async): tx_o=1, busy_o=0, fifo_read_o=0, state=IDLE, counters=0, shift reg=0.
//  States: IDLE -> START -> DATA -> STOP -> IDLE|START.
//  bit_cnt counts 0..CPB-1 cycles per bit; width $clog2(CPB); wraps to 0 at end of each bit.
//  fifo_read_o (combinational) = fifo_valid_i & (state==IDLE | end_of_last_stop_bit).
//  On the edge where fifo_read_o=1: shift reg <= fifo_data_i, state <= START, tx_o <= 0,
//  bit_cnt <= 0. Latency: pop in cycle N -> tx_o low from edge ending cycle N.
//  START: tx_o=0 for CPB cycles -> DATA. DATA: tx_o=shift[0], shift right after each bit,
//  data_idx 0..p_data_bits-1 -> STOP. STOP: tx_o=1 for p_stop_bits*CPB cycles.
//  End of last stop bit: FIFO valid -> pop and go START (no gap); else IDLE.
//  Frame length is exactly (1+p_data_bits+p_stop_bits)*CPB cycles.
//  fifo_read_o never asserts while fifo_valid_i=0; never more than one pop per frame.
//  fifo_data_i is sampled only on the pop edge; later FIFO changes do not affect the frame.
//  fifo_valid_i dropping mid-frame has no effect on the current frame.
//  Reset mid-frame: tx_o returns to 1 immediately, frame is aborted, popped word is discarded.
//  Elaboration: CPB<2, p_data_bits outside 5..8, or p_stop_bits outside 1..2 -> $error.
// STRUCTURE
//  Shared package uart_pkg: state encoding localparams (IDLE/START/DATA/STOP), frame-format
//  constants, and a CPB calculation function reused by the future RX block.
//  One sub-module: uart_baud_gen (cycle counter emitting a bit_end pulse, restartable via a
//  sync clear). It is shared with RX. The FSM, shift register and data_idx stay in this module.
// TESTING (p_clk_freq_hz=1_000_000, p_baud=100_000 -> CPB=10, p_data_bits=7, p_stop_bits=1)
//  1 Reset idle: hold rst_n_i=0, then release with fifo_valid_i=0
//    -> tx_o=1, busy_o=0, fifo_read_o=0 for 200 cycles.
//  2 Single word 7'h55 with fifo_valid_i=1 for one pop -> fifo_read_o high exactly 1 cycle;
//    tx_o line reads 0,1,0,1,0,1,0,1,1 with each bit 10 cycles long (90 cycles total);
//    busy_o returns to 0 afterwards.
//  3 Back-to-back 7'h01 then 7'h7E (FIFO model) -> two pops 90 cycles apart;
//    second start bit begins immediately after the first stop bit, with no idle cycle.
//  4 Data change after pop: change fifo_data_i to 7'h00 one cycle after popping 7'h7F
//    -> transmitted data bits are still all 1.
//  5 Async reset asserted mid-DATA (cycle 35 of a frame) -> tx_o=1 within the same cycle,
//    busy_o=0; the next frame after release is complete and correct.
//  6 Empty FIFO: fifo_valid_i=0 at end of stop bit -> state IDLE, no pop;
//    fifo_valid_i rising later -> pop on the same cycle it rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame-format constants and the
// clocks-per-bit calculation used by both the TX and RX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 8;
  localparam int unsigned MIN_STOP_BITS = 1;
  localparam int unsigned MAX_STOP_BITS = 2;
  localparam int unsigned MIN_CPB       = 2;

  function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..p_cpb-1 while enabled and flags the last cycle
// of each bit; a synchronous clear restarts the period at a frame boundary.
module uart_baud_gen #(
  parameter int unsigned p_cpb = 10
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CW = (p_cpb > 1) ? $clog2(p_cpb) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(p_cpb - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // bit_end must not depend on clr_i: the clear is driven by the pop strobe,
  // which itself is derived from bit_end.
  assign bit_end_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops words from the TX FIFO and sends them LSB-first as
// start / data / stop frames, chaining frames with no idle gap.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned p_clk_freq_hz = 50_000_000,
  parameter int unsigned p_baud        = 115_200,
  parameter int unsigned p_data_bits   = 7,
  parameter int unsigned p_stop_bits   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [p_data_bits-1:0] fifo_data_i,
  input  logic                   fifo_valid_i,
  output logic                   fifo_read_o,
  output logic                   tx_o,
  output logic                   busy_o
);

  localparam int unsigned CPB = calc_cpb(p_clk_freq_hz, p_baud);
  localparam int unsigned IW  = $clog2(p_data_bits);
  localparam logic [IW-1:0] DATA_LAST = IW'(p_data_bits - 1);
  localparam logic          STOP_LAST = 1'(p_stop_bits - 1);

  if (CPB < MIN_CPB) begin : g_bad_cpb
    $error("uart_tx_serializer: clocks per bit must be at least 2");
  end
  if (p_data_bits < MIN_DATA_BITS || p_data_bits > MAX_DATA_BITS) begin : g_bad_data
    $error("uart_tx_serializer: p_data_bits must be 5..8");
  end
  if (p_stop_bits < MIN_STOP_BITS || p_stop_bits > MAX_STOP_BITS) begin : g_bad_stop
    $error("uart_tx_serializer: p_stop_bits must be 1..2");
  end

  uart_state_e            state_q, state_d;
  logic [p_data_bits-1:0] shift_q, shift_d;
  logic [IW-1:0]          data_idx_q, data_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   bit_end;
  logic                   last_stop_end;

  uart_baud_gen #(.p_cpb(CPB)) u_baud (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (state_q != ST_IDLE),
    .clr_i     (fifo_read_o),
    .bit_end_o (bit_end)
  );

  assign last_stop_end = (state_q == ST_STOP) && bit_end && (stop_idx_q == STOP_LAST);
  assign fifo_read_o   = fifo_valid_i && ((state_q == ST_IDLE) || last_stop_end);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    data_idx_d = data_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    // A pop takes priority: it either starts from idle or chains the next frame.
    if (fifo_read_o) begin
      state_d    = ST_START;
      shift_d    = fifo_data_i;
      data_idx_d = '0;
      stop_idx_d = 1'b0;
      tx_d       = START_BIT;
    end else if (bit_end) begin
      unique case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
        ST_DATA: begin
          if (data_idx_q == DATA_LAST) begin
            state_d    = ST_STOP;
            stop_idx_d = 1'b0;
            tx_d       = STOP_BIT;
          end else begin
            shift_d    = shift_q >> 1;
            data_idx_d = data_idx_q + 1'b1;
            tx_d       = shift_q[1];
          end
        end
        ST_STOP: begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      data_idx_q <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_idx_q <= data_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
